// File: rtl/rpn_tokenizer_if.sv
// Byte-in / token-out bundle between the UART receiver, the RPN tokenizer
// and its consumers (operand stack, op_controller).
//   master: byte source side (drives rx_*, observes the token strobes)
//   slave : tokenizer side (consumes rx_*, drives the token strobes)
interface rpn_tokenizer_if #(
    parameter int DATA_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] num_out;
    logic              num_valid;
    logic              is_op;
    logic [2:0]        op_code;
    logic [1:0]        arg_cnt;
    logic              eval;
    logic              err;

    modport master (
        output rx_data, rx_valid,
        input  num_out, num_valid, is_op, op_code, arg_cnt, eval, err
    );

    modport slave (
        input  rx_data, rx_valid,
        output num_out, num_valid, is_op, op_code, arg_cnt, eval, err
    );
endinterface

// File: rtl/rpn_tokenizer.sv
// RPN tokenizer: turns an ASCII byte stream into decimal operands and
// operator / end-of-expression strobes. All outputs are registered; every
// strobe is a single-cycle pulse. An operator or '='/LF that terminates an
// operand is parked in a one-entry pending slot so the operand is always
// pushed one cycle before the operator fires.
//
// Optional feature: define RPN_HEX_EN to accept 'x'/'X'-prefixed hex operands.
module rpn_tokenizer #(
    parameter int DATA_W  = 16,
    parameter int MAX_DIG = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    rpn_tokenizer_if.slave bus
);
    localparam int MAC_W   = DATA_W + 4;
    localparam int HEX_DIG = DATA_W / 4;
    localparam int LIM_MAX = (MAX_DIG > HEX_DIG) ? MAX_DIG : HEX_DIG;
    localparam int CNT_W   = $clog2(LIM_MAX + 1);

    // Operator characters; the index is the op_code ('+'=0 ... '~'=4).
    localparam logic [39:0] OP_CHARS = {8'h7E, 8'h2F, 8'h2A, 8'h2D, 8'h2B};
    localparam int          OP_NEG   = 4;

    typedef enum logic [1:0] {S_IDLE, S_NUM, S_DISCARD} state_t;
    typedef enum logic [1:0] {P_NONE, P_OP, P_EVAL}     pend_t;

    state_t state_reg, state_next;
    pend_t  pend_reg, pend_next;

    logic [2:0]        pend_code_reg, pend_code_next;
    logic [1:0]        pend_args_reg, pend_args_next;
    logic [DATA_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]  dig_cnt_reg, dig_cnt_next;
    logic              hex_reg, hex_next;

    logic [DATA_W-1:0] num_out_reg, num_out_next;
    logic              num_valid_reg, num_valid_next;
    logic              is_op_reg, is_op_next;
    logic [2:0]        op_code_reg, op_code_next;
    logic [1:0]        arg_cnt_reg, arg_cnt_next;
    logic              eval_reg, eval_next;
    logic              err_reg, err_next;

    // Byte classification
    logic [4:0]       op_hit;
    logic             is_dec, is_hex_alpha, is_hex_start;
    logic             is_delim, is_eval_ch, is_op_ch, is_term;
    logic [3:0]       nib;
    logic [2:0]       op_code_dec;
    logic [1:0]       arg_cnt_dec;
    logic             digit_ok, tok_fault, bare_hex, take;
    logic [MAC_W-1:0] mac_dec, mac_hex, mac;
    logic [CNT_W-1:0] dig_lim;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_op_match
            assign op_hit[gi] = (bus.rx_data == OP_CHARS[gi*8 +: 8]);
        end
    endgenerate

    // Decode the incoming byte and precompute the accumulate step
    always_comb begin
        is_dec     = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
        is_delim   = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h2C);
        is_eval_ch = (bus.rx_data == 8'h3D) || (bus.rx_data == 8'h0A);
        is_op_ch   = |op_hit;
        is_term    = is_delim || is_eval_ch || is_op_ch;
`ifdef RPN_HEX_EN
        is_hex_alpha = ((bus.rx_data >= 8'h61) && (bus.rx_data <= 8'h66)) ||
                       ((bus.rx_data >= 8'h41) && (bus.rx_data <= 8'h46));
        is_hex_start = (bus.rx_data == 8'h78) || (bus.rx_data == 8'h58);
`else
        is_hex_alpha = 1'b0;
        is_hex_start = 1'b0;
`endif
        // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
        nib = is_dec ? bus.rx_data[3:0] : (bus.rx_data[3:0] + 4'd9);

        op_code_dec = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (op_hit[i]) begin
                op_code_dec = 3'(i);
            end
        end
        arg_cnt_dec = op_hit[OP_NEG] ? 2'd1 : 2'd2;

        // Wide MAC: any bit set above DATA_W means the operand no longer fits
        mac_dec = MAC_W'(acc_reg) * MAC_W'(10) + MAC_W'(bus.rx_data[3:0]);
        mac_hex = {acc_reg, nib};
        mac     = hex_reg ? mac_hex : mac_dec;
        dig_lim = hex_reg ? CNT_W'(HEX_DIG) : CNT_W'(MAX_DIG);

        digit_ok  = hex_reg ? (is_dec || is_hex_alpha) : is_dec;
        tok_fault = (dig_cnt_reg == dig_lim) || (|mac[MAC_W-1 -: 4]);
        bare_hex  = hex_reg && (dig_cnt_reg == '0);
        // A byte arriving while a deferred strobe is pending is dropped
        take      = bus.rx_valid && (pend_reg == P_NONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (take) begin
            case (state_reg)
                S_IDLE: begin
                    if (is_dec || is_hex_start) begin
                        state_next = S_NUM;
                    end else if (!is_term) begin
                        state_next = S_DISCARD;
                    end
                end
                S_NUM: begin
                    if (digit_ok) begin
                        if (tok_fault) begin
                            state_next = S_DISCARD;
                        end
                    end else if (is_term) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (is_delim || is_eval_ch) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Output and token datapath next values
    always_comb begin
        acc_next       = acc_reg;
        dig_cnt_next   = dig_cnt_reg;
        hex_next       = hex_reg;
        pend_next      = pend_reg;
        pend_code_next = pend_code_reg;
        pend_args_next = pend_args_reg;
        num_out_next   = num_out_reg;
        num_valid_next = 1'b0;
        is_op_next     = 1'b0;
        op_code_next   = op_code_reg;
        arg_cnt_next   = arg_cnt_reg;
        eval_next      = 1'b0;
        err_next       = 1'b0;

        if (pend_reg != P_NONE) begin
            // Fire the deferred strobe; a colliding byte is lost and flagged
            pend_next = P_NONE;
            if (pend_reg == P_OP) begin
                is_op_next   = 1'b1;
                op_code_next = pend_code_reg;
                arg_cnt_next = pend_args_reg;
            end else begin
                eval_next = 1'b1;
            end
            if (bus.rx_valid) begin
                err_next = 1'b1;
            end
        end else if (bus.rx_valid) begin
            case (state_reg)
                S_IDLE: begin
                    if (is_dec) begin
                        acc_next     = DATA_W'(bus.rx_data[3:0]);
                        dig_cnt_next = CNT_W'(1);
                        hex_next     = 1'b0;
                    end else if (is_hex_start) begin
                        acc_next     = '0;
                        dig_cnt_next = '0;
                        hex_next     = 1'b1;
                    end else if (is_op_ch) begin
                        is_op_next   = 1'b1;
                        op_code_next = op_code_dec;
                        arg_cnt_next = arg_cnt_dec;
                    end else if (is_eval_ch) begin
                        eval_next = 1'b1;
                    end else if (!is_delim) begin
                        err_next = 1'b1;
                    end
                end
                S_NUM: begin
                    if (digit_ok) begin
                        if (tok_fault) begin
                            err_next = 1'b1;
                        end else begin
                            acc_next     = mac[DATA_W-1:0];
                            dig_cnt_next = dig_cnt_reg + CNT_W'(1);
                        end
                    end else if (is_term) begin
                        if (bare_hex) begin
                            err_next = 1'b1;
                        end else begin
                            num_valid_next = 1'b1;
                            num_out_next   = acc_reg;
                            if (is_op_ch) begin
                                pend_next      = P_OP;
                                pend_code_next = op_code_dec;
                                pend_args_next = arg_cnt_dec;
                            end else if (is_eval_ch) begin
                                pend_next = P_EVAL;
                            end
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: begin
                    // DISCARD: everything, terminator included, is silent
                end
            endcase
        end
    end

    // Token datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg       <= '0;
            dig_cnt_reg   <= '0;
            hex_reg       <= 1'b0;
            pend_reg      <= P_NONE;
            pend_code_reg <= 3'd0;
            pend_args_reg <= 2'd0;
        end else begin
            acc_reg       <= acc_next;
            dig_cnt_reg   <= dig_cnt_next;
            hex_reg       <= hex_next;
            pend_reg      <= pend_next;
            pend_code_reg <= pend_code_next;
            pend_args_reg <= pend_args_next;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_out_reg   <= '0;
            num_valid_reg <= 1'b0;
            is_op_reg     <= 1'b0;
            op_code_reg   <= 3'd0;
            arg_cnt_reg   <= 2'd0;
            eval_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            num_out_reg   <= num_out_next;
            num_valid_reg <= num_valid_next;
            is_op_reg     <= is_op_next;
            op_code_reg   <= op_code_next;
            arg_cnt_reg   <= arg_cnt_next;
            eval_reg      <= eval_next;
            err_reg       <= err_next;
        end
    end

    assign bus.num_out   = num_out_reg;
    assign bus.num_valid = num_valid_reg;
    assign bus.is_op     = is_op_reg;
    assign bus.op_code   = op_code_reg;
    assign bus.arg_cnt   = arg_cnt_reg;
    assign bus.eval      = eval_reg;
    assign bus.err       = err_reg;
endmodule
